// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - two-master round-robin arbiter in front of the single-port RAM controller
// Optional feature macro ARB_TIMEOUT_EN: force-completes WAIT after TIMEOUT_CYC busy cycles and pulses timeout_err.
module ram_bus_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_rstrb,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rbusy,
  output logic              m0_wbusy,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_rstrb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rbusy,
  output logic              m1_wbusy,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wmask,
  output logic              s_rstrb,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rbusy,
  input  logic              s_wbusy,
  output logic [1:0]        grant
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ARM, S_WAIT} state_t;

  state_t            state, next_state;
  logic [1:0]        pending;
  logic [1:0]        is_read;
  logic [ADDR_W-1:0] slot_addr  [2];
  logic [DATA_W-1:0] slot_wdata [2];
  logic [3:0]        slot_wmask [2];
  logic [DATA_W-1:0] rdata_q    [2];
  logic              owner;
  logic              last_grant;
  logic              pick;
  logic              ctl_busy;
  logic              timeout_hit;
  logic              done;

  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [3:0]        req_wmask [2];
  logic [1:0]        req_rstrb;

  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;
  assign req_wmask[0] = m0_wmask;
  assign req_wmask[1] = m1_wmask;
  assign req_rstrb    = {m1_rstrb, m0_rstrb};

  assign ctl_busy = s_rbusy | s_wbusy;
  assign done     = !ctl_busy || timeout_hit;
  // On a tie the master that did not win last time is served.
  assign pick     = (pending == 2'b11) ? ~last_grant : pending[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      is_read <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
        slot_wmask[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!pending[i] && (req_rstrb[i] || (req_wmask[i] != 4'h0))) begin
          pending[i]    <= 1'b1;
          is_read[i]    <= req_rstrb[i];
          slot_addr[i]  <= req_addr[i];
          slot_wdata[i] <= req_wdata[i];
          slot_wmask[i] <= req_rstrb[i] ? 4'h0 : req_wmask[i];
        end
      end
      if (state == S_WAIT && done) pending[owner] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else if (state == S_WAIT && is_read[owner]) begin
      if (timeout_hit) rdata_q[owner] <= DATA_W'(32'hDEADBEEF);
      else if (ctl_busy) rdata_q[owner] <= s_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == S_IDLE && pending != 2'b00) begin
      owner      <= pick;
      last_grant <= pick;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;

  assign timeout_hit = (state == S_WAIT) && ctl_busy && (wait_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      wait_cnt    <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  // Keeps the timeout limit a live parameter in builds without the watchdog.
  if (TIMEOUT_CYC > 0) begin : g_timeout_cfg
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (pending != 2'b00) next_state = S_ISSUE;
      S_ISSUE: next_state = S_ARM;
      S_ARM:   next_state = S_WAIT;
      S_WAIT:  if (done) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wmask = 4'h0;
    s_rstrb = 1'b0;
    grant   = 2'b00;
    if (state != S_IDLE) begin
      s_addr  = slot_addr[owner];
      s_wdata = slot_wdata[owner];
      grant   = owner ? 2'b10 : 2'b01;
      if (!is_read[owner])        s_wmask = slot_wmask[owner];
      else if (state == S_ISSUE)  s_rstrb = 1'b1;
    end
  end

  // Busy is visible combinationally in the strobe cycle, before the slot latches.
  assign m0_rbusy = (pending[0] & is_read[0])  | (!pending[0] & m0_rstrb);
  assign m0_wbusy = (pending[0] & !is_read[0]) | (!pending[0] & !m0_rstrb & (m0_wmask != 4'h0));
  assign m1_rbusy = (pending[1] & is_read[1])  | (!pending[1] & m1_rstrb);
  assign m1_wbusy = (pending[1] & !is_read[1]) | (!pending[1] & !m1_rstrb & (m1_wmask != 4'h0));
  assign m0_rdata = rdata_q[0];
  assign m1_rdata = rdata_q[1];

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb/tb_ram_bus_arbiter.sv - directed self-checking bench for ram_bus_arbiter
// Build with ARB_TIMEOUT_EN defined to also exercise the WAIT watchdog.
module tb_ram_bus_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]    m0_wmask = '0, m1_wmask = '0;
  logic          m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [3:0]    s_wmask;
  logic          s_rstrb, s_rbusy, s_wbusy;
  logic [1:0]    grant;
`ifdef ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
    .grant(grant)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // Controller model: busy rises the cycle after a strobe and lasts ctl_busy_len cycles.
  // Read data is ctl_data ^ s_addr while busy, all-ones otherwise.
  logic [DW-1:0] ctl_data = '0;
  logic          ctl_stuck = 1'b0;
  int            ctl_busy_len = 2;
  int            busy_cnt;
  logic          busy_rd;
  logic [3:0]    wmask_d;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= 0;
      busy_rd  <= 1'b0;
      wmask_d  <= 4'h0;
    end else begin
      wmask_d <= s_wmask;
      if (s_rstrb) begin
        busy_cnt <= ctl_busy_len;
        busy_rd  <= 1'b1;
      end else if (s_wmask != 4'h0 && wmask_d == 4'h0) begin
        busy_cnt <= ctl_busy_len;
        busy_rd  <= 1'b0;
      end else if (busy_cnt > 0 && !ctl_stuck) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  assign s_rbusy = (busy_cnt > 0) && busy_rd;
  assign s_wbusy = (busy_cnt > 0) && !busy_rd;
  assign s_rdata = (busy_cnt > 0) ? (ctl_data ^ s_addr) : '1;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant_on(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (grant != 2'b00) ok = 1'b1;
      else cycle();
    end
  endtask

  task automatic wait_grant_off(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (grant == 2'b00) ok = 1'b1;
      else cycle();
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic strobe_read(input bit m, input logic [AW-1:0] a);
    if (m) begin m1_addr = a; m1_rstrb = 1'b1; end
    else   begin m0_addr = a; m0_rstrb = 1'b1; end
    cycle();
    m0_rstrb = 1'b0;
    m1_rstrb = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) cycle();
    checks++; if ({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy} !== 4'b0000) begin failures++; $display("FAIL reset_busy got=%b want=0000", {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}); end
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b want=00", grant); end
    checks++; if ({s_addr, s_wdata, s_wmask, s_rstrb} !== '0) begin failures++; $display("FAIL reset_s_bus got=%h/%h/%h/%b want=0", s_addr, s_wdata, s_wmask, s_rstrb); end
    checks++; if ({m0_rdata, m1_rdata} !== '0) begin failures++; $display("FAIL reset_rdata got=%h/%h want=0", m0_rdata, m1_rdata); end
    reset_n = 1'b1;
    repeat (2) cycle();
    checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_idle_grant got=%b want=00", grant); end
  endtask

  task automatic test_read_m0();
    ctl_data = 32'hA5A5_0001 ^ 32'h10;
    m0_addr = 32'h10; m0_rstrb = 1'b1;
    #1;
    checks++; if (m0_rbusy !== 1'b1 || m0_wbusy !== 1'b0) begin failures++; $display("FAIL rd_strobe_busy got=%b%b want=10", m0_rbusy, m0_wbusy); end
    cycle(); m0_rstrb = 1'b0; #1;
    checks++; if (m0_rbusy !== 1'b1 || grant !== 2'b00) begin failures++; $display("FAIL rd_idle got=busy%b grant%b want=busy1 grant00", m0_rbusy, grant); end
    cycle();
    checks++; if (grant !== 2'b01 || s_rstrb !== 1'b1 || s_addr !== 32'h10 || s_wmask !== 4'h0) begin failures++; $display("FAIL rd_issue got=g%b r%b a%h m%h want=g01 r1 a10 m0", grant, s_rstrb, s_addr, s_wmask); end
    cycle();
    checks++; if (s_rstrb !== 1'b0 || s_addr !== 32'h10 || m0_rbusy !== 1'b1) begin failures++; $display("FAIL rd_arm got=r%b a%h b%b want=r0 a10 b1", s_rstrb, s_addr, m0_rbusy); end
    cycle();
    checks++; if (grant !== 2'b01 || m0_rbusy !== 1'b1) begin failures++; $display("FAIL rd_wait got=g%b b%b want=g01 b1", grant, m0_rbusy); end
    cycle();
    checks++; if (m0_rdata !== 32'hA5A5_0001 || m0_rbusy !== 1'b1) begin failures++; $display("FAIL rd_complete got=%h b%b want=a5a50001 b1", m0_rdata, m0_rbusy); end
    cycle();
    checks++; if (grant !== 2'b00 || m0_rbusy !== 1'b0 || s_addr !== 32'h0) begin failures++; $display("FAIL rd_done got=g%b b%b a%h want=g00 b0 a0", grant, m0_rbusy, s_addr); end
    checks++; if (m0_rdata !== 32'hA5A5_0001 || m1_rdata !== 32'h0) begin failures++; $display("FAIL rd_hold got=%h/%h want=a5a50001/0", m0_rdata, m1_rdata); end
  endtask

  task automatic test_write_m1();
    m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_wmask = 4'hF;
    #1;
    checks++; if (m1_wbusy !== 1'b1 || m1_rbusy !== 1'b0 || m0_wbusy !== 1'b0) begin failures++; $display("FAIL wr_strobe got=w%b r%b m0w%b want=1 0 0", m1_wbusy, m1_rbusy, m0_wbusy); end
    cycle(); m1_wmask = 4'h0; #1;
    checks++; if (s_wmask !== 4'h0) begin failures++; $display("FAIL wr_idle_mask got=%h want=0", s_wmask); end
    cycle();
    checks++; if (grant !== 2'b10 || s_wmask !== 4'hF || s_addr !== 32'h20 || s_wdata !== 32'h1234_5678 || s_rstrb !== 1'b0) begin failures++; $display("FAIL wr_issue got=g%b m%h a%h d%h r%b want=g10 mf a20 d12345678 r0", grant, s_wmask, s_addr, s_wdata, s_rstrb); end
    cycle();
    checks++; if (s_wmask !== 4'hF || s_addr !== 32'h20) begin failures++; $display("FAIL wr_arm got=m%h a%h want=mf a20", s_wmask, s_addr); end
    cycle();
    checks++; if (s_wmask !== 4'hF || s_addr !== 32'h20 || s_wdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_wait got=m%h a%h d%h want=mf a20 d12345678", s_wmask, s_addr, s_wdata); end
    cycle();
    checks++; if (m1_wbusy !== 1'b1 || s_wmask !== 4'hF) begin failures++; $display("FAIL wr_complete got=w%b m%h want=w1 mf", m1_wbusy, s_wmask); end
    cycle();
    checks++; if (m1_wbusy !== 1'b0 || s_wmask !== 4'h0 || grant !== 2'b00) begin failures++; $display("FAIL wr_done got=w%b m%h g%b want=w0 m0 g00", m1_wbusy, s_wmask, grant); end
    checks++; if (m0_rdata !== 32'hA5A5_0001 || m0_rbusy !== 1'b0 || m1_rdata !== 32'h0) begin failures++; $display("FAIL wr_m0_untouched got=%h b%b m1=%h want=a5a50001 b0 m1=0", m0_rdata, m0_rbusy, m1_rdata); end
  endtask

  task automatic test_tie();
    bit ok;
    apply_reset();
    ctl_data = 32'hC0DE_0000;
    m0_addr = 32'h100; m1_addr = 32'h200;
    m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    cycle();
    m0_rstrb = 1'b0; m1_rstrb = 1'b0;
    wait_grant_on(ok);
    checks++; if (!ok || grant !== 2'b01 || s_addr !== 32'h100 || m1_rbusy !== 1'b1) begin failures++; $display("FAIL tie1_first got=ok%0d g%b a%h m1b%b want=ok1 g01 a100 m1b1", ok, grant, s_addr, m1_rbusy); end
    wait_grant_off(ok); wait_grant_on(ok);
    checks++; if (!ok || grant !== 2'b10 || s_addr !== 32'h200) begin failures++; $display("FAIL tie1_second got=ok%0d g%b a%h want=ok1 g10 a200", ok, grant, s_addr); end
    wait_grant_off(ok);
    checks++; if (!ok || m0_rdata !== 32'hC0DE_0100 || m1_rdata !== 32'hC0DE_0200) begin failures++; $display("FAIL tie1_rdata got=ok%0d %h/%h want=ok1 c0de0100/c0de0200", ok, m0_rdata, m1_rdata); end
    strobe_read(1'b0, 32'h300);
    wait_grant_on(ok);
    checks++; if (!ok || grant !== 2'b01) begin failures++; $display("FAIL tie_single got=ok%0d g%b want=ok1 g01", ok, grant); end
    wait_grant_off(ok);
    m0_addr = 32'h400; m1_addr = 32'h500;
    m0_rstrb = 1'b1; m1_rstrb = 1'b1;
    cycle();
    m0_rstrb = 1'b0; m1_rstrb = 1'b0;
    wait_grant_on(ok);
    checks++; if (!ok || grant !== 2'b10 || s_addr !== 32'h500) begin failures++; $display("FAIL tie2_first got=ok%0d g%b a%h want=ok1 g10 a500", ok, grant, s_addr); end
    wait_grant_off(ok); wait_grant_on(ok);
    checks++; if (!ok || grant !== 2'b01 || s_addr !== 32'h400) begin failures++; $display("FAIL tie2_second got=ok%0d g%b a%h want=ok1 g01 a400", ok, grant, s_addr); end
    wait_grant_off(ok);
    checks++; if (!ok || m0_rdata !== 32'hC0DE_0400 || m1_rdata !== 32'hC0DE_0500) begin failures++; $display("FAIL tie2_rdata got=ok%0d %h/%h want=ok1 c0de0400/c0de0500", ok, m0_rdata, m1_rdata); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ctl_data = 32'h0BAD_0000;
    strobe_read(1'b0, 32'h40);
    wait_grant_on(ok);
    cycle(); cycle();
    m1_addr = 32'h80; m1_rstrb = 1'b1;
    m0_addr = 32'h999; m0_rstrb = 1'b1;
    #1;
    checks++; if (!ok || m1_rbusy !== 1'b1 || grant !== 2'b01) begin failures++; $display("FAIL b2b_m1_busy got=ok%0d b%b g%b want=ok1 b1 g01", ok, m1_rbusy, grant); end
    cycle();
    m0_rstrb = 1'b0; m1_rstrb = 1'b0; m0_addr = '0;
    #1;
    checks++; if (s_addr !== 32'h40 || m1_rbusy !== 1'b1) begin failures++; $display("FAIL b2b_hold got=a%h b%b want=a40 b1", s_addr, m1_rbusy); end
    cycle();
    checks++; if (grant !== 2'b00 || m0_rdata !== 32'h0BAD_0040) begin failures++; $display("FAIL b2b_m0_done got=g%b %h want=g00 0bad0040", grant, m0_rdata); end
    cycle();
    checks++; if (grant !== 2'b10 || s_rstrb !== 1'b1 || s_addr !== 32'h80) begin failures++; $display("FAIL b2b_m1_issue got=g%b r%b a%h want=g10 r1 a80", grant, s_rstrb, s_addr); end
    wait_grant_off(ok);
    checks++; if (!ok || m0_rdata !== 32'h0BAD_0040 || m1_rdata !== 32'h0BAD_0080) begin failures++; $display("FAIL b2b_rdata got=ok%0d %h/%h want=ok1 0bad0040/0bad0080", ok, m0_rdata, m1_rdata); end
    repeat (3) cycle();
    checks++; if (grant !== 2'b00 || m0_rbusy !== 1'b0) begin failures++; $display("FAIL b2b_dropped got=g%b b%b want=g00 b0", grant, m0_rbusy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ctl_data = 32'h7777_0000;
    strobe_read(1'b0, 32'h60);
    wait_grant_on(ok);
    cycle(); cycle();
    reset_n = 1'b0;
    #1;
    checks++; if (!ok || grant !== 2'b00 || m0_rbusy !== 1'b0 || s_addr !== 32'h0 || s_rstrb !== 1'b0 || s_wmask !== 4'h0) begin failures++; $display("FAIL rstmid_async got=ok%0d g%b b%b a%h want=ok1 g00 b0 a0", ok, grant, m0_rbusy, s_addr); end
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata got=%h want=0", m0_rdata); end
    cycle();
    reset_n = 1'b1;
    repeat (2) cycle();
    checks++; if (grant !== 2'b00 || m0_rbusy !== 1'b0 || m1_rbusy !== 1'b0) begin failures++; $display("FAIL rstmid_empty got=g%b b%b%b want=g00 b00", grant, m0_rbusy, m1_rbusy); end
    ctl_data = 32'h1357_0000;
    strobe_read(1'b0, 32'h70);
    wait_grant_on(ok);
    checks++; if (!ok || grant !== 2'b01) begin failures++; $display("FAIL rstmid_new_grant got=ok%0d g%b want=ok1 g01", ok, grant); end
    wait_grant_off(ok);
    checks++; if (!ok || m0_rdata !== 32'h1357_0070 || m0_rbusy !== 1'b0) begin failures++; $display("FAIL rstmid_new_read got=ok%0d %h b%b want=ok1 13570070 b0", ok, m0_rdata, m0_rbusy); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n;
    apply_reset();
    ctl_stuck = 1'b1;
    ctl_data = 32'hFEED_0000;
    strobe_read(1'b0, 32'h90);
    wait_grant_on(ok);
    n = 0;
    for (int i = 0; i < 30 && timeout_err !== 1'b1; i++) begin
      cycle();
      n++;
    end
    checks++; if (!ok || timeout_err !== 1'b1 || n != 10) begin failures++; $display("FAIL to_pulse got=ok%0d te%b cycles%0d want=ok1 te1 cycles10", ok, timeout_err, n); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF || m0_rbusy !== 1'b0 || grant !== 2'b00) begin failures++; $display("FAIL to_release got=%h b%b g%b want=deadbeef b0 g00", m0_rdata, m0_rbusy, grant); end
    cycle();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_one_cycle got=%b want=0", timeout_err); end
    ctl_stuck = 1'b0;
    apply_reset();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_m0();
    test_write_m1();
    test_tie();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
